// File: rtl/window_gen_3x3.sv
// 3x3 neighbourhood generator: two row line buffers feeding a 3x3 shift window.
// Takes one raster-order pixel per accepted cycle and presents the window one clock later.
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 850,
    parameter int IMG_HEIGHT = 850,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] a3,
    output logic [DATA_W-1:0] a4,
    output logic [DATA_W-1:0] a5,
    output logic [DATA_W-1:0] a6,
    output logic [DATA_W-1:0] a7,
    output logic [DATA_W-1:0] a8,
    output logic [DATA_W-1:0] a9,
    output logic              win_valid,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]     col, col_e;
    logic [RW-1:0]     row, row_e;
    logic              col_last, row_last;
    logic [DATA_W-1:0] lb0 [IMG_WIDTH];
    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    // sof re-anchors the current pixel at (0,0) regardless of where the counters were
    always_comb begin
        col_e    = sof ? '0 : col;
        row_e    = sof ? '0 : row;
        col_last = (col_e == COL_LAST);
        row_last = (row_e == ROW_LAST);
    end

    assign lb0_rd = lb0[col_e];
    assign lb1_rd = lb1[col_e];

    // Line buffers are never cleared; validity comes only from the row/col counters
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[col_e] <= lb0_rd;
            lb0[col_e] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            a1         <= '0;
            a2         <= '0;
            a3         <= '0;
            a4         <= '0;
            a5         <= '0;
            a6         <= '0;
            a7         <= '0;
            a8         <= '0;
            a9         <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                a1 <= a2;
                a2 <= a3;
                a3 <= lb1_rd;
                a4 <= a5;
                a5 <= a6;
                a6 <= lb0_rd;
                a7 <= a8;
                a8 <= a9;
                a9 <= pix_in;
                win_valid  <= (row_e >= RW'(2)) && (col_e >= CW'(2));
                frame_done <= row_last && col_last;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row_e + RW'(1);
                end else begin
                    col <= col_e + CW'(1);
                    row <= row_e;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: small 5x4 instance for window content, 850x4 instance for count.
module tb_window_gen_3x3;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic       win_valid, frame_done;

    logic       b_pix_valid, b_sof;
    logic [7:0] b_pix_in;
    logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic       b_win_valid, b_frame_done;

    always #5 clk = ~clk;

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8), .a9(a9),
        .win_valid(win_valid), .frame_done(frame_done)
    );

    window_gen_3x3 #(.IMG_WIDTH(850), .IMG_HEIGHT(4), .DATA_W(8)) dut_big (
        .clk(clk), .rst_n(rst_n), .pix_in(b_pix_in), .pix_valid(b_pix_valid), .sof(b_sof),
        .a1(b1), .a2(b2), .a3(b3), .a4(b4), .a5(b5), .a6(b6), .a7(b7), .a8(b8), .a9(b9),
        .win_valid(b_win_valid), .frame_done(b_frame_done)
    );

    logic [71:0] win_now;
    assign win_now = {a1, a2, a3, a4, a5, a6, a7, a8, a9};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: collect windows, frame_done info and gap/hold violations
    logic [71:0] got[$];
    logic [71:0] exp_q[$];
    logic [71:0] fd_win, prev_win;
    int          fd_cnt, fd_nowin, gap_err, hold_err, b_wins, b_fd;
    logic        acc_last, hold_ok;

    always @(posedge clk) begin
        acc_last = rst_n && pix_valid;
        hold_ok  = rst_n && !pix_valid;
    end

    always @(negedge clk) begin
        if (win_valid === 1'b1) got.push_back(win_now);
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_win = win_now;
            if (win_valid !== 1'b1) fd_nowin++;
        end
        if (win_valid === 1'b1 && !acc_last) gap_err++;
        if (hold_ok && win_now !== prev_win) hold_err++;
        prev_win = win_now;
        if (b_win_valid === 1'b1) b_wins++;
        if (b_frame_done === 1'b1) b_fd++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_scen();
        got.delete();
        exp_q.delete();
        fd_cnt   = 0;
        fd_nowin = 0;
        fd_win   = '0;
    endtask

    // Reference windows for a ramp frame with pixel(r,c) = base + r*W + c
    task automatic add_exp(input int base);
        logic [7:0] p [H][W];
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                p[r][c] = 8'(base + r * W + c);
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                exp_q.push_back({p[r-2][c-2], p[r-2][c-1], p[r-2][c],
                                 p[r-1][c-2], p[r-1][c-1], p[r-1][c],
                                 p[r][c-2],   p[r][c-1],   p[r][c]});
    endtask

    task automatic send_frame(input int base, input bit use_sof, input bit gaps, input bit chk_first);
        for (int i = 0; i < W * H; i++) begin
            pix_in    = 8'(base + i);
            pix_valid = 1'b1;
            sof       = use_sof && (i == 0);
            step();
            if (chk_first && i == 11) check("pre_first_wv", {71'd0, win_valid}, 72'd1 - 72'd1);
            if (chk_first && i == 12) begin
                check("first_wv", {71'd0, win_valid}, 72'd1);
                check("first_win", win_now, {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12});
            end
            if (gaps) begin
                pix_valid = 1'b0;
                sof       = 1'b0;
                pix_in    = 8'hEE;
                step();
            end
        end
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic finish_scen(input string tag, input int n_fd);
        repeat (3) step();
        check({tag, "_count"}, 72'(got.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check($sformatf("%s_win%0d", tag, i), got[i], exp_q[i]);
        check({tag, "_fd_cnt"}, 72'(fd_cnt), 72'(n_fd));
        check({tag, "_fd_last_win"}, fd_win, exp_q[exp_q.size()-1]);
        check({tag, "_fd_without_wv"}, 72'(fd_nowin), 72'd0);
    endtask

    initial begin
        gap_err  = 0;
        hold_err = 0;
        b_wins   = 0;
        b_fd     = 0;
        clear_scen();
        b_pix_valid = 1'b0;
        b_sof       = 1'b0;
        b_pix_in    = '0;

        // Reset held with pix_valid high
        rst_n     = 1'b0;
        pix_valid = 1'b1;
        sof       = 1'b0;
        pix_in    = 8'hAA;
        repeat (3) step();
        check("rst_window", win_now, 72'd0);
        check("rst_win_valid", {71'd0, win_valid}, 72'd0);
        check("rst_frame_done", {71'd0, frame_done}, 72'd0);
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        step();
        clear_scen();

        // Counters must already sit at (0,0): ramp without sof
        add_exp(0);
        send_frame(0, 1'b0, 1'b0, 1'b1);
        finish_scen("post_rst", 1);

        clear_scen();
        add_exp(0);
        send_frame(0, 1'b1, 1'b0, 1'b1);
        finish_scen("ramp", 1);

        clear_scen();
        add_exp(0);
        send_frame(0, 1'b1, 1'b1, 1'b0);
        finish_scen("bubble", 1);

        clear_scen();
        add_exp(0);
        add_exp(100);
        send_frame(0, 1'b1, 1'b0, 1'b0);
        send_frame(100, 1'b1, 1'b0, 1'b0);
        finish_scen("b2b", 2);

        // Partial frame of 8 pixels then reset
        for (int i = 0; i < 8; i++) begin
            pix_in    = 8'(i);
            pix_valid = 1'b1;
            sof       = (i == 0);
            step();
        end
        sof   = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        step();
        clear_scen();
        add_exp(0);
        send_frame(0, 1'b1, 1'b0, 1'b0);
        finish_scen("mid_rst", 1);

        // Stray pixels, then sof resynchronises
        clear_scen();
        for (int i = 0; i < 8; i++) begin
            pix_in    = 8'(50 + i);
            pix_valid = 1'b1;
            sof       = 1'b0;
            step();
        end
        add_exp(0);
        send_frame(0, 1'b1, 1'b0, 1'b0);
        finish_scen("sof_resync", 1);

        check("gap_win_valid", 72'(gap_err), 72'd0);
        check("gap_hold", 72'(hold_err), 72'd0);

        // Full-width 850x4 frame
        for (int i = 0; i < 850 * 4; i++) begin
            b_pix_in    = 8'(i);
            b_pix_valid = 1'b1;
            b_sof       = (i == 0);
            step();
        end
        b_pix_valid = 1'b0;
        b_sof       = 1'b0;
        repeat (3) step();
        check("big_win_count", 72'(b_wins), 72'd1696);
        check("big_fd_count", 72'(b_fd), 72'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
